sponge_absorb_ctrl: RTL and testbench

- Parametrised absorb-phase controller for the team's lightweight sponge constructions.
- Takes a packed message buffer of up to NUMBLOCKS rate-sized blocks and a sponge state (c, r, x).
- For each block it XORs the block into the rate, invokes the external permutation core F through a start/done handshake, and latches F's output.
- It adds optional 10* pad-block insertion and domain-separation injection on the final call, and returns the updated state with a one-cycle done pulse.

---
 rtl/sponge_absorb_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sponge_absorb_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sponge_absorb_ctrl.sv
// -----------------------------------------------------------------------------
// sponge_absorb_ctrl
//
// Absorb-phase controller for the lightweight sponge constructions. On an
// accepted start it loads the sponge state (c, r, x), then for each message
// block XORs the block into the rate, calls the external permutation F through
// a start/done handshake and latches F's result. An optional 10* pad block is
// appended when the message is not already padded, and the domain bits are
// XORed into the low capacity bits just before the last permutation call when
// finalize is set. Completion is flagged with a one-cycle done pulse.
//
// BWIDTH must equal RWIDTH and NUMBLOCKS must be at least 1. CWIDTH must be at
// least 2, because the domain bits land in c[1:0].
//
// Ports
//   clk                          rising-edge clock
//   reset                        synchronous, active-low reset
//   start                        operation request, sampled only while idle
//   c, r, x                      initial sponge state, loaded on accepted start
//   blocks                       packed message, block i = blocks[i*BWIDTH +: BWIDTH];
//                                read live during each absorb step, so it must
//                                stay stable until done
//   nblocks                      valid block count, clamps to NUMBLOCKS
//   padded                       1 = message already padded, 0 = append pad block
//   finalize                     1 = inject domain before the last F call
//   domain                       domain-separation bits
//   perm_start                   one-cycle request to F
//   perm_c, perm_r, perm_x       F inputs, straight from the state registers
//   perm_cout, perm_rout,
//   perm_xout                    F outputs
//   perm_done                    F result valid (one-cycle pulse)
//   busy                         high in every state except idle
//   done                         one-cycle completion pulse
//   cout, rout, xout             state registers; valid with done, held until
//                                the next accepted start
// -----------------------------------------------------------------------------
module sponge_absorb_ctrl #(
  parameter int unsigned CWIDTH    = 320,
  parameter int unsigned RWIDTH    = 32,
  parameter int unsigned XWIDTH    = 64,
  parameter int unsigned BWIDTH    = 32,
  parameter int unsigned NUMBLOCKS = 4,
  localparam int unsigned NW       = $clog2(NUMBLOCKS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CWIDTH-1:0]           c,
  input  logic [RWIDTH-1:0]           r,
  input  logic [XWIDTH-1:0]           x,
  input  logic [BWIDTH*NUMBLOCKS-1:0] blocks,
  input  logic [NW-1:0]               nblocks,
  input  logic                        padded,
  input  logic                        finalize,
  input  logic [1:0]                  domain,
  output logic                        perm_start,
  output logic [CWIDTH-1:0]           perm_c,
  output logic [RWIDTH-1:0]           perm_r,
  output logic [XWIDTH-1:0]           perm_x,
  input  logic [CWIDTH-1:0]           perm_cout,
  input  logic [RWIDTH-1:0]           perm_rout,
  input  logic [XWIDTH-1:0]           perm_xout,
  input  logic                        perm_done,
  output logic                        busy,
  output logic                        done,
  output logic [CWIDTH-1:0]           cout,
  output logic [RWIDTH-1:0]           rout,
  output logic [XWIDTH-1:0]           xout
);

  // total can reach NUMBLOCKS + 1 (clamped count plus a pad block).
  localparam int unsigned TW = $clog2(NUMBLOCKS + 2);

  typedef enum logic [2:0] {
    StIdle,
    StAbsorb,
    StPerm,
    StWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [CWIDTH-1:0] c_q, c_d;
  logic [RWIDTH-1:0] r_q, r_d;
  logic [XWIDTH-1:0] x_q, x_d;
  logic [TW-1:0]     idx_q, idx_d;
  logic [TW-1:0]     total_q, total_d;
  // Clamped message block count; indices at or above it select the pad block.
  logic [TW-1:0]     nmsg_q, nmsg_d;
  logic              fin_q, fin_d;
  logic [1:0]        dom_q, dom_d;

  // Start-time decode of the requested block count. The padded flag is fully
  // captured by total, so it needs no register of its own.
  logic [TW-1:0] nmsg_in;
  logic [TW-1:0] total_in;

  always_comb begin
    nmsg_in = TW'(nblocks);
    if (nblocks > NW'(NUMBLOCKS)) begin
      nmsg_in = TW'(NUMBLOCKS);
    end
    total_in = nmsg_in + (padded ? TW'(0) : TW'(1));
  end

  // Block for the current absorb step: message block idx, or the 10* pad block.
  logic [BWIDTH-1:0] blk;

  always_comb begin
    blk = BWIDTH'(1);
    for (int unsigned i = 0; i < NUMBLOCKS; i++) begin
      if ((idx_q == TW'(i)) && (idx_q < nmsg_q)) begin
        blk = blocks[i*BWIDTH +: BWIDTH];
      end
    end
  end

  logic last_call;
  assign last_call = (idx_q == (total_q - TW'(1)));

  logic [TW-1:0] idx_inc;
  assign idx_inc = idx_q + TW'(1);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    x_d     = x_q;
    idx_d   = idx_q;
    total_d = total_q;
    nmsg_d  = nmsg_q;
    fin_d   = fin_q;
    dom_d   = dom_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          c_d     = c;
          r_d     = r;
          x_d     = x;
          idx_d   = '0;
          total_d = total_in;
          nmsg_d  = nmsg_in;
          fin_d   = finalize;
          dom_d   = domain;
          // An empty, already padded message needs no permutation call.
          state_d = (total_in == '0) ? StDone : StAbsorb;
        end
      end

      StAbsorb: begin
        r_d = r_q ^ RWIDTH'(blk);
        if (last_call && fin_q) begin
          c_d[1:0] = c_q[1:0] ^ dom_q;
        end
        state_d = StPerm;
      end

      StPerm: begin
        state_d = StWait;
      end

      StWait: begin
        if (perm_done) begin
          c_d     = perm_cout;
          r_d     = perm_rout;
          x_d     = perm_xout;
          idx_d   = idx_inc;
          state_d = (idx_inc == total_q) ? StDone : StAbsorb;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      c_q     <= '0;
      r_q     <= '0;
      x_q     <= '0;
      idx_q   <= '0;
      total_q <= '0;
      nmsg_q  <= '0;
      fin_q   <= 1'b0;
      dom_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      total_q <= total_d;
      nmsg_q  <= nmsg_d;
      fin_q   <= fin_d;
      dom_q   <= dom_d;
    end
  end

  // Control outputs decode straight from the state register, so reset clears
  // them along with the FSM.
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign perm_start = (state_q == StPerm);

  assign perm_c = c_q;
  assign perm_r = r_q;
  assign perm_x = x_q;

  assign cout = c_q;
  assign rout = r_q;
  assign xout = x_q;

endmodule

// File: tb/tb_sponge_absorb_ctrl.sv
module tb_sponge_absorb_ctrl;

  localparam int unsigned CW = 320;
  localparam int unsigned RW = 32;
  localparam int unsigned XW = 64;
  localparam int unsigned BW = 32;
  localparam int unsigned NB = 4;
  localparam int unsigned NWB = $clog2(NB + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [CW-1:0]     c_in = '0;
  logic [RW-1:0]     r_in = '0;
  logic [XW-1:0]     x_in = '0;
  logic [BW*NB-1:0]  blocks = '0;
  logic [NWB-1:0]    nblocks = '0;
  logic              padded = 1'b0;
  logic              finalize = 1'b0;
  logic [1:0]        domain = '0;
  logic              perm_start;
  logic [CW-1:0]     perm_c;
  logic [RW-1:0]     perm_r;
  logic [XW-1:0]     perm_x;
  logic [CW-1:0]     stub_c = '0;
  logic [RW-1:0]     stub_r = '0;
  logic [XW-1:0]     stub_x = '0;
  logic              stub_done = 1'b0;
  logic              extra_done = 1'b0;
  logic              perm_done;
  logic              busy;
  logic              done;
  logic [CW-1:0]     cout;
  logic [RW-1:0]     rout;
  logic [XW-1:0]     xout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stub permutation: latency 1, r' = r + 1, c and x pass through.
  always @(posedge clk) begin
    stub_done <= perm_start;
    stub_c    <= perm_c;
    stub_r    <= perm_r + RW'(1);
    stub_x    <= perm_x;
  end
  assign perm_done = stub_done | extra_done;

  sponge_absorb_ctrl #(
    .CWIDTH   (CW),
    .RWIDTH   (RW),
    .XWIDTH   (XW),
    .BWIDTH   (BW),
    .NUMBLOCKS(NB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .c         (c_in),
    .r         (r_in),
    .x         (x_in),
    .blocks    (blocks),
    .nblocks   (nblocks),
    .padded    (padded),
    .finalize  (finalize),
    .domain    (domain),
    .perm_start(perm_start),
    .perm_c    (perm_c),
    .perm_r    (perm_r),
    .perm_x    (perm_x),
    .perm_cout (stub_c),
    .perm_rout (stub_r),
    .perm_xout (stub_x),
    .perm_done (perm_done),
    .busy      (busy),
    .done      (done),
    .cout      (cout),
    .rout      (rout),
    .xout      (xout)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: absorb the message block by block with the stub's arithmetic.
  function automatic void model(input logic [CW-1:0] c0, input logic [RW-1:0] r0,
                                input logic [XW-1:0] x0, input logic [BW*NB-1:0] blk,
                                input int nb_req, input bit pad, input bit fin,
                                input logic [1:0] dom, output logic [CW-1:0] ce,
                                output logic [RW-1:0] re, output logic [XW-1:0] xe,
                                output int k);
    int nb;
    logic [RW-1:0] b;
    nb = (nb_req > int'(NB)) ? int'(NB) : nb_req;
    k  = nb + (pad ? 0 : 1);
    ce = c0;
    re = r0;
    xe = x0;
    for (int i = 0; i < k; i++) begin
      b  = (i < nb) ? blk[i*BW +: BW] : RW'(1);
      re = re ^ b;
      if (i == k - 1 && fin) ce[1:0] = ce[1:0] ^ dom;
      re = re + RW'(1);
    end
  endfunction

  // Launch one operation and check control outputs and results every cycle.
  // restart_at >= 0 pulses a stray start with different captured inputs.
  task automatic run_op(input logic [CW-1:0] c0, input logic [RW-1:0] r0,
                        input logic [XW-1:0] x0, input logic [BW*NB-1:0] blk,
                        input int nb, input bit pad, input bit fin, input logic [1:0] dom,
                        input int restart_at, input string tag, output int pulses);
    logic [CW-1:0] ce;
    logic [RW-1:0] re;
    logic [XW-1:0] xe;
    int k;
    int d;
    model(c0, r0, x0, blk, nb, pad, fin, dom, ce, re, xe, k);
    d = (k == 0) ? 0 : 3 * k;
    @(negedge clk);
    c_in = c0; r_in = r0; x_in = x0; blocks = blk; nblocks = NWB'(nb);
    padded = pad; finalize = fin; domain = dom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int n = 0; n <= d + 1; n++) begin
      chk({tag, " busy"}, 512'(busy), 512'(n <= d));
      chk({tag, " done"}, 512'(done), 512'(n == d));
      chk({tag, " perm_start"}, 512'(perm_start), 512'(k > 0 && n < d && n % 3 == 1));
      if (perm_start) pulses++;
      if (n >= d) begin
        chk({tag, " cout"}, 512'(cout), 512'(ce));
        chk({tag, " rout"}, 512'(rout), 512'(re));
        chk({tag, " xout"}, 512'(xout), 512'(xe));
      end
      if (n == restart_at && n < d) begin
        c_in = ~c0; r_in = ~r0; x_in = ~x0; nblocks = NWB'($urandom_range(0, 7));
        padded = ~pad; finalize = ~fin; domain = ~dom; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, " pulse count"}, 512'(pulses), 512'(k));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CW-1:0] rc;
    logic [RW-1:0] rr;
    logic [XW-1:0] rx;
    logic [BW*NB-1:0] rb;
    int pulses;

    // Reset held with start and perm_done active.
    reset = 1'b0;
    start = 1'b1;
    nblocks = 3'd2;
    padded = 1'b1;
    c_in = {10{32'hdeadbeef}};
    r_in = 32'h1234;
    x_in = 64'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      extra_done = ~extra_done;
      chk("reset busy", 512'(busy), 512'(0));
      chk("reset done", 512'(done), 512'(0));
      chk("reset perm_start", 512'(perm_start), 512'(0));
      chk("reset cout", 512'(cout), 512'(0));
      chk("reset rout", 512'(rout), 512'(0));
      chk("reset xout", 512'(xout), 512'(0));
    end
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    extra_done = 1'b0;

    // Two pre-padded blocks.
    rc = {10{32'ha5a5_0f0f}};
    rx = 64'h0123_4567_89ab_cdef;
    rb = '0;
    rb[31:0] = 32'h11;
    rb[63:32] = 32'h22;
    run_op(rc, 32'h0, rx, rb, 2, 1'b1, 1'b0, 2'b00, -1, "two", pulses);
    chk("two lit rout", 512'(rout), 512'(32'h31));
    chk("two lit cout", 512'(cout), 512'(rc));
    chk("two lit pulses", 512'(pulses), 512'(2));

    // Pad insertion.
    rb = '0;
    rb[31:0] = 32'h05;
    run_op(rc, 32'h0, rx, rb, 1, 1'b0, 1'b0, 2'b00, -1, "pad", pulses);
    chk("pad lit rout", 512'(rout), 512'(32'h08));
    chk("pad lit pulses", 512'(pulses), 512'(2));

    // Domain injection on / off.
    rb[31:0] = 32'h07;
    run_op('0, 32'h9, rx, rb, 1, 1'b1, 1'b1, 2'b11, -1, "dom_on", pulses);
    chk("dom_on lit cout", 512'(cout), 512'(3));
    run_op('0, 32'h9, rx, rb, 1, 1'b1, 1'b0, 2'b11, -1, "dom_off", pulses);
    chk("dom_off lit cout", 512'(cout), 512'(0));

    // Empty pre-padded message.
    run_op(rc, 32'hcafe, rx, rb, 0, 1'b1, 1'b1, 2'b10, -1, "empty", pulses);
    chk("empty lit pulses", 512'(pulses), 512'(0));
    chk("empty lit rout", 512'(rout), 512'(32'hcafe));

    // Clamp of nblocks above NUMBLOCKS.
    run_op(rc, 32'h0, rx, {32'h4, 32'h3, 32'h2, 32'h1}, 7, 1'b1, 1'b0, 2'b00, -1, "clamp",
           pulses);
    chk("clamp lit pulses", 512'(pulses), 512'(4));

    // Stray start during WAIT.
    run_op(rc, 32'h10, rx, {32'h4, 32'h3, 32'h2, 32'h1}, 3, 1'b0, 1'b1, 2'b01, 2, "busy_start",
           pulses);

    // Reset in WAIT, then a late perm_done.
    @(negedge clk);
    c_in = rc; r_in = 32'h77; x_in = rx; nblocks = 3'd2; padded = 1'b1; finalize = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midreset perm_start", 512'(perm_start), 512'(1));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    extra_done = 1'b1;
    chk("midreset busy", 512'(busy), 512'(0));
    chk("midreset rout", 512'(rout), 512'(0));
    chk("midreset cout", 512'(cout), 512'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      extra_done = 1'b0;
      chk("midreset idle busy", 512'(busy), 512'(0));
      chk("midreset idle done", 512'(done), 512'(0));
      chk("midreset idle perm_start", 512'(perm_start), 512'(0));
      chk("midreset idle xout", 512'(xout), 512'(0));
    end

    // Randomized operations.
    for (int t = 0; t < 40; t++) begin
      for (int w = 0; w < 10; w++) rc[w*32 +: 32] = $urandom();
      rr = $urandom();
      rx = {$urandom(), $urandom()};
      for (int w = 0; w < int'(NB); w++) rb[w*32 +: 32] = $urandom();
      run_op(rc, rr, rx, rb, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 2 : -1, "rand", pulses);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
